vga_sync_out: RTL
=================

# vga_sync_out

Pixel-timing generator and output stage for the VGA monitor path. It counts a 640x480@60 raster from the system clock and publishes the pixel coordinates `pix_x`/`pix_y` to the text writer. It takes the writer's colour back, registers it, and drives the aligned `hsync_n`, `vsync_n` and `rgb` pins. The writer sits between this block's coordinate output and its colour input; the font ROM sits beside the writer.

## Interface
- `DIV`, 2: system clocks per pixel (50 MHz → 25 MHz); legal range 1..16.
- `H_DISP`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_DISP`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- Constraint: H_TOTAL = sum of the four H parameters, V_TOTAL = sum of the four V parameters; both must be ≤ 1024.

Ports:
- `clk`  in  1: system clock. This is the only clock; all logic is rising-edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `rgb_in`  in  3: colour from the text writer for the current `pix_x`/`pix_y`; combinational within the same clock.
- `pix_x`  out  10: current horizontal count, 0..H_TOTAL-1.
- `pix_y`  out  10: current vertical count, 0..V_TOTAL-1.
- `p_tick`  out  1: one-clock pixel strobe.
- `video_on`  out  1: high when the current coordinates are inside the visible area.
- `hsync_n`  out  1: horizontal sync, active low, registered.
- `vsync_n`  out  1: vertical sync, active low, registered.
- `rgb`  out  3: pixel colour pins, registered, blanked outside the visible area.
- `frame_start`  out  1: one-clock pulse at each wrap of the raster to (0,0).

## Operation
- **Divider.** `div_cnt` counts 0..DIV-1 and wraps.
  - `p_tick` = (`div_cnt` == DIV-1) && `rst_n`.
  - With DIV=1, `p_tick` is high on every clock while out of reset.
- **Horizontal counter.** `h_cnt` advances only on `p_tick`. At H_TOTAL-1 it wraps to 0.
- **Vertical counter.** `v_cnt` advances only on a `p_tick` where `h_cnt` == H_TOTAL-1. At V_TOTAL-1 it wraps to 0.
- **Coordinates.** `pix_x` = `h_cnt` and `pix_y` = `v_cnt`, taken directly from the registers with no extra delay.
- **Visible area.** `video_on` = (`h_cnt` < H_DISP) && (`v_cnt` < V_DISP). It is combinational.
- **Output stage.** Updates only on `p_tick`, using the counter values present before the increment:
  - `hsync_n` ← !(H_DISP+H_FP ≤ `h_cnt` < H_DISP+H_FP+H_SYNC), i.e. low for `h_cnt` 656..751 with defaults.
  - `vsync_n` ← !(V_DISP+V_FP ≤ `v_cnt` < V_DISP+V_FP+V_SYNC), i.e. low for `v_cnt` 490..491 with defaults.
  - `rgb` ← `video_on` ? `rgb_in` : 3'b000.
- **Frame pulse.** `frame_start` is a register. It is set for exactly one clock after the `p_tick` on which `h_cnt` == H_TOTAL-1 and `v_cnt` == V_TOTAL-1, and is 0 otherwise. It is not asserted on the way out of reset.
- **Reset.** While `rst_n` is low on a clock edge, the following are applied regardless of the current state (including mid-line or mid-frame):
  - `div_cnt` = 0, `h_cnt` = 0, `v_cnt` = 0.
  - `hsync_n` = 1, `vsync_n` = 1, `rgb` = 0, `frame_start` = 0.
  - `p_tick` = 0 and `video_on` = 1, both following the counters.

## Timing
- **Pixel period.** DIV clocks. The first `p_tick` after reset release comes DIV clocks after the first clock edge with `rst_n` high.
- **Line and frame length.** Line = H_TOTAL·DIV clocks (1600). Frame = H_TOTAL·V_TOTAL·DIV clocks (840 000).
- **Output latency.** One pixel. The pins show the pixel whose coordinates were present during the previous pixel period, so the `rgb` sample taken at (x, y) appears with the sync levels belonging to (x, y).
- **Colour sampling.** `rgb_in` must be stable on the `p_tick` clock. It is ignored on all other clocks.
- **Sync widths.** `hsync_n` low = H_SYNC·DIV clocks per line. `vsync_n` low = V_SYNC·H_TOTAL·DIV clocks per frame.
- **Simultaneous wraps.** An `h_cnt` wrap and a `v_cnt` wrap on the same `p_tick` both take effect on that edge, and `frame_start` follows on the next clock.

## Test plan
- **Reset values.** Hold `rst_n` = 0 for 5 clocks → `pix_x` = `pix_y` = 0, `hsync_n` = `vsync_n` = 1, `rgb` = 0, `p_tick` = 0, `frame_start` = 0.
- **Tick cadence.** DIV=2, release reset → `p_tick` high on clocks 2, 4, 6, …; `pix_x` reads 1 after the first tick; `pix_x` goes 799 → 0 with `pix_y` 0 → 1 at clock 1600.
- **Horizontal sync.** On line 0, `hsync_n` falls on the tick after `pix_x` = 656 and rises on the tick after `pix_x` = 752 → low for exactly 192 clocks. `vsync_n` stays 1.
- **Frame wrap.** Run a full frame → `vsync_n` low for 3200 clocks starting after `pix_y` 490 is first sampled; `frame_start` is a single-clock pulse at clock 840 001; the raster is back at (0,0).
- **Blanking.** Drive `rgb_in` = 3'b110 constantly → `rgb` = 110 for visible pixels only. `rgb` = 000 on the tick after `pix_x` = 640 is sampled and across `pix_y` 480..524.
- **Mid-frame reset.** Assert `rst_n` = 0 for one clock at `pix_x` = 700, `pix_y` = 491 → the next clock shows all reset values (`vsync_n` = 1) and counting restarts cleanly from 0.

Source files
------------

// File: rtl/vga_sync_out.sv
// Pixel-timing generator and registered output stage for the VGA monitor path.
// Counts the raster, publishes pixel coordinates, and drives aligned sync and colour pins.
module vga_sync_out #(
    parameter int DIV    = 2,
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rgb_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       p_tick,
    output logic       video_on,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic [2:0] rgb,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    // Compare in 11 bits so a 1024-wide raster cannot truncate its bounds.
    localparam logic [3:0]  DIV_LAST = 4'(DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISP);
    localparam logic [10:0] V_VIS    = 11'(V_DISP);
    localparam logic [10:0] HS_START = 11'(H_DISP + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISP + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_DISP + V_FP + V_SYNC);

    logic [3:0]  div_cnt_r;
    logic [9:0]  h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic [10:0] h_ext_s;
    logic [10:0] v_ext_s;
    logic        tick_s;
    logic        h_last_s;
    logic        v_last_s;
    logic        visible_s;
    logic        hs_active_s;
    logic        vs_active_s;
    logic        hsync_n_r;
    logic        vsync_n_r;
    logic [2:0]  rgb_r;
    logic        frame_start_r;

    // Decode the current raster position into tick, wrap, visible and sync flags.
    always_comb begin
        h_ext_s     = {1'b0, h_cnt_r};
        v_ext_s     = {1'b0, v_cnt_r};
        tick_s      = 1'b0;
        if (rst_n && (div_cnt_r == DIV_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        h_last_s    = (h_ext_s == H_LAST);
        v_last_s    = (v_ext_s == V_LAST);
        visible_s   = (h_ext_s < H_VIS) && (v_ext_s < V_VIS);
        hs_active_s = (h_ext_s >= HS_START) && (h_ext_s < HS_END);
        vs_active_s = (v_ext_s >= VS_START) && (v_ext_s < VS_END);
    end

    // Clock divider producing one pixel strobe every DIV system clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r <= 4'd0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 4'd0;
        end else begin
            div_cnt_r <= div_cnt_r + 4'd1;
        end
    end

    // Horizontal and vertical raster counters; both wraps may land on the same tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (tick_s) begin
            if (h_last_s) begin
                h_cnt_r <= 10'd0;
                if (v_last_s) begin
                    v_cnt_r <= 10'd0;
                end else begin
                    v_cnt_r <= v_cnt_r + 10'd1;
                end
            end else begin
                h_cnt_r <= h_cnt_r + 10'd1;
                v_cnt_r <= v_cnt_r;
            end
        end else begin
            h_cnt_r <= h_cnt_r;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Output pins take the pre-increment position, giving one pixel of latency
    // so colour and sync levels for the same coordinate appear together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_n_r <= 1'b1;
            vsync_n_r <= 1'b1;
            rgb_r     <= 3'b000;
        end else if (tick_s) begin
            hsync_n_r <= !hs_active_s;
            vsync_n_r <= !vs_active_s;
            rgb_r     <= visible_s ? rgb_in : 3'b000;
        end else begin
            hsync_n_r <= hsync_n_r;
            vsync_n_r <= vsync_n_r;
            rgb_r     <= rgb_r;
        end
    end

    // Single-clock pulse following the tick that wraps the raster back to (0,0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= tick_s && h_last_s && v_last_s;
        end
    end

    assign pix_x       = h_cnt_r;
    assign pix_y       = v_cnt_r;
    assign p_tick      = tick_s;
    assign video_on    = visible_s;
    assign hsync_n     = hsync_n_r;
    assign vsync_n     = vsync_n_r;
    assign rgb         = rgb_r;
    assign frame_start = frame_start_r;

endmodule
